pipelined_addsub: RTL

Parametrised, pipelined adder/subtractor: the next-generation integer add path of the processor datapath, replacing the fixed 16-bit single-cycle ripple adder. Splits a WIDTH-bit add or subtract into STAGES carry-chained slices, one slice per clock, with a valid/ready handshake on both sides. Accepts one operation per cycle and produces result, carry-out and optional status flags STAGES cycles later.

---
 rtl/cpu_alu_pkg.sv | 16 +
 rtl/addsub_slice.sv | 21 ++
 rtl/pipelined_addsub.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cpu_alu_pkg.sv
// Shared ALU datapath definitions: default operand width, op encoding,
// and the status-flag bundle produced by the add/subtract path.
package cpu_alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  typedef struct packed {
    logic ovf;
    logic neg;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/addsub_slice.sv
// One carry-chained slice of the pipelined adder: SW-bit add with carry-in/out.
module addsub_slice #(
  parameter int unsigned SW = 4
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] s,
  output logic          co
);

  logic [SW:0] sum;

  // Plain ripple add; the pipeline registers carry between slices.
  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};
    s   = sum[SW-1:0];
    co  = sum[SW];
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor, STAGES carry-chained slices, one per clock.
// Global-advance valid/ready pipeline. Optional status flags (ovf, neg, zero)
// are built when PIPELINED_ADDSUB_FLAGS_EN is defined.
module pipelined_addsub
  import cpu_alu_pkg::*;
#(
  parameter int unsigned WIDTH  = ALU_WIDTH,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] rb,
  input  logic [WIDTH-1:0] rc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ra,
  output logic             cout
`ifdef PIPELINED_ADDSUB_FLAGS_EN
  ,
  output logic             ovf,
  output logic             neg,
  output logic             zero
`endif
);

  localparam int unsigned SW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  logic             advance;
  logic [WIDTH-1:0] eff_rc;

  // Operands, partial sum and carry seen by each stage's slice this cycle.
  logic [WIDTH-1:0] op_a  [STAGES];
  logic [WIDTH-1:0] op_b  [STAGES];
  logic [WIDTH-1:0] op_s  [STAGES];
  logic [WIDTH-1:0] nxt_s [STAGES];
  logic [SW-1:0]    sl_s  [STAGES];
  logic [STAGES-1:0] op_ci;
  logic [STAGES-1:0] op_v;
  logic [STAGES-1:0] sl_co;

  // Stage registers: skewed operands, deskewed result slices, carry, valid.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign eff_rc   = (in_sub == ALU_OP_SUB) ? ~rc : rc;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LSB = k * SW;

    if (k == 0) begin : g_head
      assign op_a[k]  = rb;
      assign op_b[k]  = eff_rc;
      assign op_s[k]  = '0;
      assign op_ci[k] = in_sub;
      assign op_v[k]  = in_valid;
    end else begin : g_body
      assign op_a[k]  = a_q[k-1];
      assign op_b[k]  = b_q[k-1];
      assign op_s[k]  = s_q[k-1];
      assign op_ci[k] = c_q[k-1];
      assign op_v[k]  = v_q[k-1];
    end

    addsub_slice #(.SW(SW)) u_slice (
      .a  (op_a[k][LSB +: SW]),
      .b  (op_b[k][LSB +: SW]),
      .ci (op_ci[k]),
      .s  (sl_s[k]),
      .co (sl_co[k])
    );

    // Bits above the slices completed so far are always zero, so OR-merge suffices.
    assign nxt_s[k] = op_s[k] | (WIDTH'(sl_s[k]) << LSB);
  end

  // Shift every stage forward together on advance; otherwise hold the whole pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        s_q[i] <= '0;
      end
    end else if (advance) begin
      v_q <= op_v;
      c_q <= sl_co;
      for (int unsigned i = 0; i < STAGES; i++) begin
        a_q[i] <= op_a[i];
        b_q[i] <= op_b[i];
        s_q[i] <= nxt_s[i];
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign ra        = s_q[LAST];
  assign cout      = c_q[LAST];

`ifdef PIPELINED_ADDSUB_FLAGS_EN
  alu_flags_t flags_d;
  alu_flags_t flags_q;

  // Flags derived from the final stage's full sum and operand sign bits.
  always_comb begin
    flags_d      = '0;
    flags_d.neg  = nxt_s[LAST][WIDTH-1];
    flags_d.zero = (nxt_s[LAST] == '0);
    flags_d.ovf  = (op_a[LAST][WIDTH-1] == op_b[LAST][WIDTH-1]) &&
                   (nxt_s[LAST][WIDTH-1] != op_a[LAST][WIDTH-1]);
  end

  // Flags register alongside ra so they stay aligned and stable under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (advance) begin
      flags_q <= flags_d;
    end
  end

  assign ovf  = flags_q.ovf;
  assign neg  = flags_q.neg;
  assign zero = flags_q.zero;
`endif

endmodule
